// File: rtl/dmem_ws_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ws_pkg
// Definitions shared by the wait-state data memory and its storage bank:
//   - access size encodings (byte / half / word / double)
//   - FSM state type
//   - log2 helper for sizing index and lane fields from parameters
// -----------------------------------------------------------------------------
package dmem_ws_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2; only ever called on powers of two here.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// Word-organised storage with byte enables. Read is combinational from index,
// write happens on the rising clock edge for every byte whose enable is set.
// Contents are never reset.
//
// Ports
//   clk    : clock
//   we     : write strobe for this cycle
//   be     : byte enables, one per byte lane of the word
//   index  : word index
//   wdata  : write data, already steered to its byte lanes
//   rdata  : word currently stored at index
// -----------------------------------------------------------------------------
module dmem_bank
    import dmem_ws_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64
)
(
    input  logic                       clk,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [log2(DEPTH)-1:0]     index,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[index];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ws.sv
// -----------------------------------------------------------------------------
// dmem_ws
// Data memory with a fixed number of wait states per access. One access is in
// flight at a time: IDLE accepts a request, WAIT burns WAIT cycles, RESP holds
// the response until the consumer takes it. Loads are sign- or zero-extended,
// stores update only the addressed bytes. Misaligned, out-of-range and illegal
// size accesses return resp_err=1 with zero data and leave memory untouched.
//
// Parameters
//   DATA_W : word width, 32 or 64
//   DEPTH  : number of words, power of two
//   WAIT   : wait states per access, 0..15
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous reset, active low
//   req_valid    : request presented
//   req_ready    : block can accept a request (IDLE only)
//   req_we       : 1 = store, 0 = load
//   req_addr     : byte address
//   req_wdata    : store data, right-aligned
//   req_size     : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned : load zero-extends when 1, sign-extends when 0
//   resp_valid   : response presented
//   resp_ready   : consumer accepts the response
//   resp_rdata   : load result, 0 for stores and errors
//   resp_err     : access error
// -----------------------------------------------------------------------------
module dmem_ws
    import dmem_ws_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int          NB    = DATA_W / 8;
    localparam int          OFF_W = log2(NB);
    localparam int          IDX_W = log2(DEPTH);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);

    state_t            state;
    logic [3:0]        cnt;

    logic              we_p1;
    logic              uns_p1;
    logic [63:0]       addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [1:0]        size_p1;

    logic              accept;
    logic              enter_resp;
    logic              acc_we;
    logic              acc_uns;
    logic [63:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [1:0]        acc_size;

    logic [OFF_W-1:0]  lane;
    logic [IDX_W-1:0]  index;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              acc_err;
    logic [NB-1:0]     be_base;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_lane;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] load_data;
    logic              bank_we;

    // Keep the 2^size low bytes of raw and extend them to DATA_W. A full-width
    // access has an all-ones mask, so the extension term vanishes.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        sz,
        input logic              uns
    );
        logic [DATA_W-1:0] mask;
        logic              sbit;
        case (sz)
            SZ_B:    begin mask = DATA_W'(8'hFF);         sbit = raw[7];  end
            SZ_H:    begin mask = DATA_W'(16'hFFFF);      sbit = raw[15]; end
            SZ_W:    begin mask = DATA_W'(32'hFFFF_FFFF); sbit = raw[31]; end
            default: begin mask = '1;                     sbit = 1'b0;    end
        endcase
        if (!uns && sbit) return (raw & mask) | ~mask;
        return raw & mask;
    endfunction

    assign accept = req_valid & req_ready;

    // With WAIT=0 the access completes on the acceptance edge itself, before the
    // request has been captured, so the datapath looks at the live inputs in IDLE.
    assign acc_we    = (state == ST_IDLE) ? req_we       : we_p1;
    assign acc_uns   = (state == ST_IDLE) ? req_unsigned : uns_p1;
    assign acc_addr  = (state == ST_IDLE) ? req_addr     : addr_p1;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata    : wdata_p1;
    assign acc_size  = (state == ST_IDLE) ? req_size     : size_p1;

    assign enter_resp = (accept && (WAIT == 0)) || (state == ST_WAIT && cnt == 4'd1);

    assign lane  = acc_addr[OFF_W-1:0];
    assign index = acc_addr[OFF_W +: IDX_W];

    always_comb begin
        misaligned = 1'b0;
        be_base    = '0;
        case (acc_size)
            SZ_B:    begin misaligned = 1'b0;            be_base = NB'(8'h01); end
            SZ_H:    begin misaligned = acc_addr[0];     be_base = NB'(8'h03); end
            SZ_W:    begin misaligned = |acc_addr[1:0];  be_base = NB'(8'h0F); end
            default: begin misaligned = |acc_addr[2:0];  be_base = NB'(8'hFF); end
        endcase
    end

    assign out_of_range = (acc_addr >= LIMIT);
    assign bad_size     = (acc_size == SZ_D) && (DATA_W == 32);
    assign acc_err      = misaligned | out_of_range | bad_size;

    assign be         = be_base << lane;
    assign wdata_lane = acc_wdata << {lane, 3'b000};
    assign bank_we    = enter_resp & acc_we & ~acc_err;
    assign load_data  = (acc_err || acc_we) ? '0
                      : extend_load(bank_rdata >> {lane, 3'b000}, acc_size, acc_uns);

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk    (clk),
        .we     (bank_we),
        .be     (be),
        .index  (index),
        .wdata  (wdata_lane),
        .rdata  (bank_rdata)
    );

    // ---- request capture (data only, not reset) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p1    <= req_we;
            uns_p1   <= req_unsigned;
            addr_p1  <= req_addr;
            wdata_p1 <= req_wdata;
            size_p1  <= req_size;
        end
    end

    // ---- control FSM and registered response ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= 4'(WAIT);
                        state     <= (WAIT == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                ST_RESP: begin
                    // req_ready rises with the return to IDLE, so no request
                    // can be taken on the handshake edge itself.
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ws.sv
module tb_dmem_ws;

    logic        clk;
    logic        reset;

    // main instance, WAIT=2
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    // second instance, WAIT=0
    logic        w0_req_valid, w0_req_ready, w0_req_we, w0_req_unsigned;
    logic [63:0] w0_req_addr, w0_req_wdata;
    logic [1:0]  w0_req_size;
    logic        w0_resp_valid, w0_resp_ready, w0_resp_err;
    logic [63:0] w0_resp_rdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_ws #(.DATA_W(64), .DEPTH(64), .WAIT(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_ws #(.DATA_W(64), .DEPTH(64), .WAIT(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(w0_req_valid), .req_ready(w0_req_ready), .req_we(w0_req_we),
        .req_addr(w0_req_addr), .req_wdata(w0_req_wdata), .req_size(w0_req_size),
        .req_unsigned(w0_req_unsigned),
        .resp_valid(w0_resp_valid), .resp_ready(w0_resp_ready),
        .resp_rdata(w0_resp_rdata), .resp_err(w0_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting on the DUT", nm);
    endtask

    task automatic add(input string nm, input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [1:0] sz, input logic uns,
                       input logic [63:0] er, input logic ee);
        vec_t v;
        v.name = nm; v.we = we; v.addr = addr; v.wdata = wd; v.size = sz;
        v.uns = uns; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input string nm);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) timeout(nm);
    endtask

    // One complete access on the WAIT=2 instance with resp_ready held high.
    // Request inputs are scrambled right after acceptance; they must be ignored.
    task automatic access(input string nm, input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [1:0] sz, input logic uns,
                          output logic [63:0] rd, output logic er, output int lat);
        wait_ready({nm, "_ready"});
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = uns; resp_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                req_valid = 1'b0; req_we = ~we; req_addr = ~addr;
                req_wdata = ~wd; req_size = ~sz; req_unsigned = ~uns;
            end
            lat++;
        end while (!resp_valid && lat < 50);
        if (!resp_valid) begin
            timeout({nm, "_resp"});
        end else begin
            rd = resp_rdata;
            er = resp_err;
            @(posedge clk);
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          guard;
        int          n_acc;
        int          n_rsp;

        reset = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0;
        req_unsigned = 0; resp_ready = 0;
        w0_req_valid = 0; w0_req_we = 0; w0_req_addr = 0; w0_req_wdata = 0;
        w0_req_size = 0; w0_req_unsigned = 0; w0_resp_ready = 0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_req_ready",  {63'd0, req_ready},  64'd0);
        chk("rst_resp_err",   {63'd0, resp_err},   64'd0);
        chk("rst_resp_rdata", resp_rdata,          64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready",    {63'd0, req_ready},    64'd1);
        chk("rel_w0_req_ready", {63'd0, w0_req_ready}, 64'd1);

        // directed vectors on the WAIT=2 instance
        add("st_d_10",   1, 64'h10,  64'h1122334455667788, 2'd3, 0, 64'h0, 0);
        add("ld_d_10",   0, 64'h10,  64'h0, 2'd3, 0, 64'h1122334455667788, 0);
        add("ld_b_17s",  0, 64'h17,  64'h0, 2'd0, 0, 64'h11, 0);
        add("st_b_11",   1, 64'h11,  64'hDEADBEEFCAFE0080, 2'd0, 0, 64'h0, 0);
        add("ld_b_11s",  0, 64'h11,  64'h0, 2'd0, 0, 64'hFFFFFFFFFFFFFF80, 0);
        add("ld_b_11u",  0, 64'h11,  64'h0, 2'd0, 1, 64'h80, 0);
        add("st_h_13",   1, 64'h13,  64'hBEEF, 2'd1, 0, 64'h0, 1);
        add("ld_d_10b",  0, 64'h10,  64'h0, 2'd3, 0, 64'h1122334455668088, 0);
        add("ld_w_14s",  0, 64'h14,  64'h0, 2'd2, 0, 64'h11223344, 0);
        add("st_w_1c",   1, 64'h1C,  64'h89ABCDEF, 2'd2, 0, 64'h0, 0);
        add("ld_w_1cs",  0, 64'h1C,  64'h0, 2'd2, 0, 64'hFFFFFFFF89ABCDEF, 0);
        add("ld_w_1cu",  0, 64'h1C,  64'h0, 2'd2, 1, 64'h89ABCDEF, 0);
        add("ld_h_1es",  0, 64'h1E,  64'h0, 2'd1, 0, 64'hFFFFFFFFFFFF89AB, 0);
        add("ld_h_1eu",  0, 64'h1E,  64'h0, 2'd1, 1, 64'h89AB, 0);
        add("ld_d_200",  0, 64'h200, 64'h0, 2'd3, 0, 64'h0, 1);
        add("st_b_200",  1, 64'h200, 64'h5A, 2'd0, 0, 64'h0, 1);
        add("st_d_1f8",  1, 64'h1F8, 64'h0123456789ABCDEF, 2'd3, 0, 64'h0, 0);
        add("ld_d_1f8",  0, 64'h1F8, 64'h0, 2'd3, 1, 64'h0123456789ABCDEF, 0);
        add("ld_b_1ffs", 0, 64'h1FF, 64'h0, 2'd0, 0, 64'h01, 0);
        add("ld_b_1f8u", 0, 64'h1F8, 64'h0, 2'd0, 1, 64'hEF, 0);
        add("ld_w_1fa",  0, 64'h1FA, 64'h0, 2'd2, 0, 64'h0, 1);
        add("ld_d_11",   0, 64'h11,  64'h0, 2'd3, 0, 64'h0, 1);
        add("st_d_20",   1, 64'h20,  64'h5555555555555555, 2'd3, 0, 64'h0, 0);

        foreach (vecs[i]) begin
            access(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].size, vecs[i].uns, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'd3);
        end

        // backpressure: response held for 5 cycles while request inputs wiggle
        wait_ready("bp_ready");
        req_valid = 1; req_we = 0; req_addr = 64'h10; req_size = 2'd3;
        req_unsigned = 0; resp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_valid) timeout("bp_resp");
        req_valid = 1; req_we = 1; req_addr = 64'h1C; req_wdata = 64'h0; req_size = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_resp_rdata", resp_rdata, 64'h1122334455668088);
            chk("bp_req_ready",  {63'd0, req_ready},  64'd0);
        end
        req_valid = 0;
        resp_ready = 1;
        @(negedge clk);
        chk("bp_after_req_ready",  {63'd0, req_ready},  64'd1);
        chk("bp_after_resp_valid", {63'd0, resp_valid}, 64'd0);
        access("bp_chk_1c", 0, 64'h1C, 64'h0, 2'd2, 1, rd, er, lat);
        chk("bp_chk_1c_rdata", rd, 64'h89ABCDEF);

        // reset while a load response is being held
        wait_ready("rr_ready");
        req_valid = 1; req_we = 0; req_addr = 64'h10; req_size = 2'd3; resp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_valid) timeout("rr_resp");
        reset = 1'b0;
        #1;
        chk("rr_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rr_resp_rdata", resp_rdata,          64'd0);
        chk("rr_req_ready",  {63'd0, req_ready},  64'd0);
        @(negedge clk);
        reset = 1'b1;
        resp_ready = 1;

        // reset during WAIT of a byte store: the store must not land
        wait_ready("rs_ready");
        req_valid = 1; req_we = 1; req_addr = 64'h20; req_wdata = 64'hAA;
        req_size = 2'd0; req_unsigned = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        reset = 1'b0;
        #1;
        chk("rs_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rs_resp_err",   {63'd0, resp_err},   64'd0);
        chk("rs_resp_rdata", resp_rdata,          64'd0);
        chk("rs_req_ready",  {63'd0, req_ready},  64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_rel_req_ready", {63'd0, req_ready}, 64'd1);
        access("rs_ld_20", 0, 64'h20, 64'h0, 2'd3, 0, rd, er, lat);
        chk("rs_ld_20_rdata", rd, 64'h5555555555555555);
        chk("rs_ld_20_err", {63'd0, er}, 64'd0);

        // WAIT=0 instance: single-cycle latency store then load
        @(negedge clk);
        w0_req_valid = 1; w0_req_we = 1; w0_req_addr = 64'h08;
        w0_req_wdata = 64'hCAFEF00D12345678; w0_req_size = 2'd3; w0_resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        w0_req_valid = 0;
        chk("w0_st_latency1", {63'd0, w0_resp_valid}, 64'd1);
        chk("w0_st_err",      {63'd0, w0_resp_err},   64'd0);
        @(negedge clk);
        w0_req_valid = 1; w0_req_we = 0; w0_req_addr = 64'h08; w0_req_size = 2'd3;
        w0_req_unsigned = 0;
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            if (w0_req_ready) n_acc++;
            @(negedge clk);
            if (w0_resp_valid) begin
                n_rsp++;
                chk("w0_ld_rdata", w0_resp_rdata, 64'hCAFEF00D12345678);
            end
        end
        w0_req_valid = 0;
        chk("w0_accepts_in_10", 64'(n_acc), 64'd5);
        chk("w0_resps_in_10",   64'(n_rsp), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_ws.md
DMEM_WS -- requirements
Module: dmem_ws

Interface
REQ-001 Parameter DATA_W, default 64, data word width in bits; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 64, number of DATA_W words; must be a power of two.
REQ-003 Parameter WAIT, default 2, wait states per access; legal range is 0..15.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1 bit: a request is presented.
REQ-007 Port req_ready, output, 1 bit: the block can accept a request.
REQ-008 Port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-009 Port req_addr, input, 64 bits: byte address.
REQ-010 Port req_wdata, input, DATA_W bits: store data, right-aligned.
REQ-011 Port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = double (3 is legal only when DATA_W=64).
REQ-012 Port req_unsigned, input, 1 bit: load zero-extends when 1 and sign-extends when 0.
REQ-013 Port resp_valid, output, 1 bit: a response is presented.
REQ-014 Port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-015 Port resp_rdata, output, DATA_W bits: load result; 0 for stores and for errors.
REQ-016 Port resp_err, output, 1 bit: the access was misaligned, out of range or an illegal size.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-019 On acceptance, the block SHALL register we, addr, wdata, size and unsigned, and SHALL load the wait counter with WAIT.
- Next state is WAIT when WAIT>0.
- Next state is RESP when WAIT=0.
REQ-020 In WAIT, the counter SHALL decrement once per cycle; the FSM SHALL move to RESP on the edge where the counter is 1.
REQ-021 resp_valid SHALL first be asserted WAIT+1 cycles after the acceptance edge.
REQ-022 resp_valid SHALL stay at 1, with resp_rdata and resp_err stable, until resp_valid and resp_ready are both 1 at an edge; the FSM then returns to IDLE.
REQ-023 A new request SHALL NOT be accepted on the same edge as a response handshake; the minimum spacing between requests is WAIT+2 cycles.
REQ-024 Word index SHALL be addr[log2(DATA_W/8) +: log2(DEPTH)]; byte lane SHALL be addr[log2(DATA_W/8)-1:0].
REQ-025 Error conditions:
- addr is not a multiple of 2^size;
- addr >= DEPTH*DATA_W/8;
- size=3 when DATA_W=32.
On error: resp_err=1, resp_rdata=0, memory is unchanged.
REQ-026 Store: the block SHALL write only the 2^size addressed bytes of the word, taken from the low bytes of wdata, on the edge that enters RESP; all other bytes are unchanged.
REQ-027 Load: the block SHALL extract the addressed bytes, extend them per req_unsigned to DATA_W, and register the result on the edge that enters RESP.
REQ-028 A size equal to DATA_W SHALL ignore req_unsigned.
REQ-029 Request inputs outside an acceptance edge SHALL be ignored; changing them during WAIT or RESP has no effect.

Reset
REQ-030 Asserting reset, at any time including mid-access, SHALL immediately force the following:
- state = IDLE;
- counter = 0;
- resp_valid = 0, resp_err = 0, resp_rdata = 0;
- req_ready = 0 while reset is asserted.
REQ-031 An access in flight when reset asserts SHALL be discarded; a store in flight SHALL NOT be written.
REQ-032 Memory array contents SHALL NOT be reset.
REQ-033 req_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-034 A shared package SHALL hold:
- the size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
- the FSM state enum;
- a log2 helper function.
REQ-035 The storage array SHALL be a sub-module dmem_bank with ports clk, we, a byte-enable vector, index, wdata and rdata.
REQ-036 dmem_bank SHALL have combinational read and synchronous write.
REQ-037 dmem_ws SHALL contain only the FSM, alignment/range checks, lane steering and extension logic.

Verification
REQ-038 Store/load double, WAIT=2: store 0x1122334455667788 at 0x10, then load 0x10 size 3 -> resp_rdata=0x1122334455667788; resp_valid appears exactly 3 cycles after each acceptance.
REQ-039 Sign extension: load byte at 0x17 signed -> 0x0000000000000011; store byte 0x80 at 0x11, then load 0x11 signed -> 0xFFFFFFFFFFFFFF80; the same load unsigned -> 0x80.
REQ-040 Misaligned access: half store at 0x13 -> resp_err=1, resp_rdata=0; a following load double of 0x10 shows the word unchanged.
REQ-041 Out of range, DEPTH=64: load at 0x200 -> resp_err=1.
REQ-042 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready stays 0; set resp_ready=1 -> req_ready=1 on the next cycle.
REQ-043 Reset mid-store: assert reset during WAIT of a store of 0xAA at 0x20 -> outputs clear immediately; after release, load 0x20 returns the prior value.
REQ-044 WAIT=0: load latency is 1 cycle and back-to-back requests are accepted every 2 cycles.
